bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces the fixed 6-bit/2-digit combinational converter in the watch display path. Seconds, minutes, hours and the wider alarm and stopwatch counters all go through one interface with a start/busy/done handshake. The registered BCD result feeds the 7-segment digit decoders directly.

---
 rtl/bin_to_bcd_seq.sv | 170 +++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock. A start pulse in IDLE captures bin. BIN_W clocks
// later the registered result appears on bcd together with a one-cycle done
// pulse. bcd and overflow hold their values until the next done.
//
// Parameters:
//   BIN_W   binary input width, 1..32
//   DIGITS  number of BCD output digits, 1..10
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   conversion request, sampled only while idle
//   bin       in   binary value, captured on the accepted start edge
//   busy      out  high while a conversion is in progress
//   done      out  one-cycle pulse when bcd/overflow have been updated
//   bcd       out  result, digit k in bcd[4k+3:4k]
//   overflow  out  last result did not fit in DIGITS digits
//                  (bcd then holds bin mod 10^DIGITS)
//
// Optional feature (compile-time macro):
//   BIN_TO_BCD_BLANK_EN  leading-zero blanking. Each most-significant zero
//                        digit above digit 0 is loaded as 4'hF, which the
//                        segment decoder shows as blank. The reset value
//                        stays all-zero.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q,  state_d;
  logic [BIN_W-1:0]   shift_q,  shift_d;
  logic [BCD_W-1:0]   work_q,   work_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               sticky_q, sticky_d;
  logic [BCD_W-1:0]   bcd_q,    bcd_d;
  logic               ovf_q,    ovf_d;
  logic               done_q,   done_d;

  // Add-3 correction applied to every digit independently (no inter-digit
  // carry), then one left shift with the next binary bit entering at bit 0.
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               top_bit;
  logic [BCD_W-1:0]   load_val;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                              (work_q[4*gi +: 4] + 4'd3) : work_q[4*gi +: 4];
    end
  endgenerate

  assign shifted = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
  // The bit shifted out of the top digit carries weight 10^DIGITS or more;
  // dropping it leaves the lower digits as bin mod 10^DIGITS.
  assign top_bit = adj[BCD_W-1];

`ifdef BIN_TO_BCD_BLANK_EN
  // blank[k]: digit k and every digit above it are zero. Evaluated from the
  // top digit downward so blanking stops at the first non-zero digit.
  // Digit 0 is always shown.
  logic [DIGITS-1:0] blank;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_d0
        assign blank[gi] = 1'b0;
      end else if (gi == DIGITS - 1) begin : g_top
        assign blank[gi] = (shifted[4*gi +: 4] == 4'd0);
      end else begin : g_mid
        assign blank[gi] = (shifted[4*gi +: 4] == 4'd0) & blank[gi+1];
      end
      assign load_val[4*gi +: 4] = blank[gi] ? 4'hF : shifted[4*gi +: 4];
    end
  endgenerate
`else
  assign load_val = shifted;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = bin;
          work_d   = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        work_d   = shifted;
        shift_d  = shift_q << 1;
        cnt_d    = cnt_q + CNT_W'(1);
        sticky_d = sticky_q | top_bit;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = load_val;
          ovf_d   = sticky_q | top_bit;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Drives three converter instances (6b/2 digits, 7b/2 digits, 17b/5 digits).
// Each accepted start pushes the expected result and its due cycle onto a
// per-instance queue; a monitor pops and compares on every done pulse.
// Honours BIN_TO_BCD_BLANK_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 6-bit / 2-digit instance
  logic        st6 = 1'b0;
  logic [5:0]  bin6 = '0;
  logic        busy6, done6, ovf6;
  logic [7:0]  bcd6;
  exp_t        q6[$];

  // 7-bit / 2-digit instance
  logic        st7 = 1'b0;
  logic [6:0]  bin7 = '0;
  logic        busy7, done7, ovf7;
  logic [7:0]  bcd7;
  exp_t        q7[$];

  // 17-bit / 5-digit instance
  logic        st17 = 1'b0;
  logic [16:0] bin17 = '0;
  logic        busy17, done17, ovf17;
  logic [19:0] bcd17;
  exp_t        q17[$];

  bin_to_bcd_seq #(.BIN_W(6), .DIGITS(2)) u6 (
    .clk(clk), .rst_n(rst_n), .start(st6), .bin(bin6),
    .busy(busy6), .done(done6), .bcd(bcd6), .overflow(ovf6));

  bin_to_bcd_seq #(.BIN_W(7), .DIGITS(2)) u7 (
    .clk(clk), .rst_n(rst_n), .start(st7), .bin(bin7),
    .busy(busy7), .done(done7), .bcd(bcd7), .overflow(ovf7));

  bin_to_bcd_seq #(.BIN_W(17), .DIGITS(5)) u17 (
    .clk(clk), .rst_n(rst_n), .start(st17), .bin(bin17),
    .busy(busy17), .done(done17), .bcd(bcd17), .overflow(ovf17));

  // Reference model: decimal digits by repeated division
  function automatic logic [39:0] model_bcd(input longint v, input int digits);
    logic [39:0] r;
    longint      x;
    r = '0;
    x = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN_TO_BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = digits - 1; k >= 1; k--) begin
        if (lead && r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic model_ovf(input longint v, input int digits);
    longint p;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    return (v >= p);
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done6) begin
      vectors++;
      if (q6.size() == 0) begin
        miscompares++;
        $display("FAIL u6_unexpected_done: done=1 at cyc %0d, required no done", cyc);
      end else begin
        e = q6.pop_front();
        if (bcd6 !== e.bcd[7:0] || ovf6 !== e.ovf || cyc !== e.due || busy6 !== 1'b0) begin
          miscompares++;
          $display("FAIL u6_result: bcd=%h ovf=%b cyc=%0d busy=%b, required bcd=%h ovf=%b cyc=%0d busy=0",
                   bcd6, ovf6, cyc, busy6, e.bcd[7:0], e.ovf, e.due);
        end else
          $display("u6  bcd=%h ovf=%b at cyc %0d ok", bcd6, ovf6, cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done7) begin
      vectors++;
      if (q7.size() == 0) begin
        miscompares++;
        $display("FAIL u7_unexpected_done: done=1 at cyc %0d, required no done", cyc);
      end else begin
        e = q7.pop_front();
        if (bcd7 !== e.bcd[7:0] || ovf7 !== e.ovf || cyc !== e.due || busy7 !== 1'b0) begin
          miscompares++;
          $display("FAIL u7_result: bcd=%h ovf=%b cyc=%0d busy=%b, required bcd=%h ovf=%b cyc=%0d busy=0",
                   bcd7, ovf7, cyc, busy7, e.bcd[7:0], e.ovf, e.due);
        end else
          $display("u7  bcd=%h ovf=%b at cyc %0d ok", bcd7, ovf7, cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done17) begin
      vectors++;
      if (q17.size() == 0) begin
        miscompares++;
        $display("FAIL u17_unexpected_done: done=1 at cyc %0d, required no done", cyc);
      end else begin
        e = q17.pop_front();
        if (bcd17 !== e.bcd[19:0] || ovf17 !== e.ovf || cyc !== e.due || busy17 !== 1'b0) begin
          miscompares++;
          $display("FAIL u17_result: bcd=%h ovf=%b cyc=%0d busy=%b, required bcd=%h ovf=%b cyc=%0d busy=0",
                   bcd17, ovf17, cyc, busy17, e.bcd[19:0], e.ovf, e.due);
        end else
          $display("u17 bcd=%h ovf=%b at cyc %0d ok", bcd17, ovf17, cyc);
      end
    end
  end

  // ---------------- drivers ----------------
  // Called #1 after the accepting edge: done is due BIN_W cycles later.
  task automatic push6(input logic [5:0] v);
    exp_t e;
    e.bcd = model_bcd(longint'(v), 2);
    e.ovf = model_ovf(longint'(v), 2);
    e.due = cyc + 6;
    q6.push_back(e);
  endtask

  task automatic start6(input logic [5:0] v);
    @(negedge clk);
    bin6 = v; st6 = 1'b1;
    @(posedge clk); #1;
    push6(v);
    st6 = 1'b0;
  endtask

  task automatic start7(input logic [6:0] v);
    exp_t e;
    @(negedge clk);
    bin7 = v; st7 = 1'b1;
    @(posedge clk); #1;
    e.bcd = model_bcd(longint'(v), 2);
    e.ovf = model_ovf(longint'(v), 2);
    e.due = cyc + 7;
    q7.push_back(e);
    st7 = 1'b0;
  endtask

  task automatic start17(input logic [16:0] v);
    exp_t e;
    @(negedge clk);
    bin17 = v; st17 = 1'b1;
    @(posedge clk); #1;
    e.bcd = model_bcd(longint'(v), 5);
    e.ovf = model_ovf(longint'(v), 5);
    e.due = cyc + 17;
    q17.push_back(e);
    st17 = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been seen.
  task automatic wait_drain();
    int n;
    n = 0;
    while ((q6.size() + q7.size() + q17.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((q6.size() + q7.size() + q17.size()) != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0",
               q6.size() + q7.size() + q17.size());
      q6.delete(); q7.delete(); q17.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy6, done6, ovf6, bcd6} !== '0 || {busy7, done7, ovf7, bcd7} !== '0 ||
        {busy17, done17, ovf17, bcd17} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: u6=%b%b%b%h u7=%b%b%b%h u17=%b%b%b%h, required all zero",
               busy6, done6, ovf6, bcd6, busy7, done7, ovf7, bcd7, busy17, done17, ovf17, bcd17);
    end else
      $display("reset values ok");
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start6(6'd63);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (busy6 !== 1'b1 || done6 !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_busy: cycle %0d busy=%b done=%b, required busy=1 done=0", i, busy6, done6);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] held;
    start6(6'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done6 !== 1'b1 && n < 20);
    if (done6 !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL b2b_done_timeout: done=%b, required 1", done6);
    end
    // Start in the done cycle itself.
    held = model_bcd(0, 2);
    bin6 = 6'd9; st6 = 1'b1;
    @(posedge clk); #1;
    push6(6'd9);
    st6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (bcd6 !== held || busy6 !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_hold: bcd=%h busy=%b, required bcd=%h busy=1", bcd6, busy6, held);
      end
    end
    wait_drain();
  endtask

  task automatic test_start_held();
    @(negedge clk);
    bin6 = 6'd10; st6 = 1'b1;
    @(posedge clk); #1;
    push6(6'd10);
    @(negedge clk); bin6 = 6'd20;
    @(negedge clk); bin6 = 6'd30;
    @(negedge clk); st6 = 1'b0; bin6 = 6'd41;
    wait_drain();
    repeat (8) @(negedge clk);   // any extra conversion would show up here
  endtask

  task automatic test_overflow();
    start7(7'd127);
    wait_drain();
    start7(7'd99);
    wait_drain();
    start7(7'd100);
    wait_drain();
  endtask

  task automatic test_wide();
    start17(17'd86399);
    wait_drain();
    start17(17'd5);
    wait_drain();
    start17(17'd131071);
    wait_drain();
    start17(17'd40007);
    wait_drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      start6(6'($urandom_range(0, 63)));
      start7(7'($urandom_range(0, 127)));
      wait_drain();
    end
  endtask

  task automatic test_reset_midway();
    start6(6'd45);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy6 !== 1'b0 || done6 !== 1'b0 || bcd6 !== 8'h00 || ovf6 !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_values: busy=%b done=%b bcd=%h ovf=%b, required 0 0 00 0",
               busy6, done6, bcd6, ovf6);
    end else
      $display("mid-conversion reset ok");
    q6.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (done6 !== 1'b0 || busy6 !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_no_done: done=%b busy=%b, required 0 0", done6, busy6);
      end
    end
    start6(6'd37);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_held();
    test_overflow();
    test_wide();
    test_random();
    test_reset_midway();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
